mod_counter: RTL and testbench
==============================

MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 Parameter: WIDTH, 4, count width in bits; SHALL be legal for 2..32.
REQ-002 Parameter: MODULUS, 16, count range 0..MODULUS-1; SHALL be legal for 2..2^WIDTH.
REQ-003 Parameter: SATURATE, 0; 0 = wrap at range ends, 1 = hold at range ends.
REQ-004 Port: CLK  input  1  sole clock; all state SHALL change on its rising edge only, except reset.
REQ-005 Port: reset  input  1  asynchronous, active-low reset; low forces reset state immediately, regardless of CLK.
REQ-006 Port: en  input  1  count enable; one step per enabled cycle.
REQ-007 Port: up_dn  input  1  direction; 1 = increment, 0 = decrement.
REQ-008 Port: clr  input  1  synchronous clear to 0.
REQ-009 Port: load  input  1  synchronous parallel load.
REQ-010 Port: load_val  input  WIDTH  value applied on load.
REQ-011 Port: count  output  WIDTH  registered current count.
REQ-012 Port: tc  output  1  terminal count, combinational: en & (up_dn ? count==MODULUS-1 : count==0).
REQ-013 Port: wrap  output  1  registered one-cycle pulse; high in the cycle after the count wrapped or was held at a limit.
REQ-014 Port: load_err  output  1  sticky flag for an out-of-range load.

Function
REQ-015 Per-edge priority SHALL be clr > load > en; with none of them asserted, count holds.
REQ-016 clr SHALL set count=0 and wrap=0; load_err is unaffected.
REQ-017 load with load_val<MODULUS SHALL set count=load_val.
REQ-018 load with load_val>=MODULUS SHALL set count=MODULUS-1 and set load_err=1.
REQ-019 load_err SHALL stay 1 until reset; clr does not clear it.
REQ-020 en with up_dn=1 and count<MODULUS-1 SHALL set count=count+1.
REQ-021 en with up_dn=0 and count>0 SHALL set count=count-1.
REQ-022 With SATURATE=0, en at the terminal value SHALL wrap: MODULUS-1 goes to 0 when counting up; 0 goes to MODULUS-1 when counting down.
REQ-023 With SATURATE=1, en at the terminal value SHALL hold count unchanged.
REQ-024 wrap SHALL be 1 for exactly one cycle after any enabled step taken while tc=1, in either mode, and 0 otherwise.
REQ-025 Back-to-back enabled steps at the terminal SHALL each produce a wrap pulse.
REQ-026 A direction change SHALL take effect on the same edge, with no dead cycle.
REQ-027 tc SHALL be gated by the current en and up_dn values, so it reflects a direction change within the same cycle.
REQ-028 Arithmetic SHALL be modulo MODULUS; count SHALL never leave 0..MODULUS-1, including when MODULUS=2^WIDTH.
REQ-029 load or clr in the same cycle as a terminal step SHALL suppress the wrap pulse for that edge.
REQ-030 Latency: count reflects a clr, load or step one edge after the cycle it was sampled in.

Reset
REQ-031 While reset=0: count=0, wrap=0, load_err=0; tc follows REQ-012 from count=0.
REQ-032 Asserting reset mid-count SHALL clear state asynchronously, with no partial update.
REQ-033 The first rising CLK edge after reset deasserts SHALL be a normal functional edge.
REQ-034 No state SHALL depend on initial-value declarations; reset alone defines the start state.

Verification (WIDTH=4, MODULUS=10 unless stated)
REQ-035 Hold reset low, then release it; apply en=1, up_dn=1 for 12 cycles -> count 1..9, 0, 1, 2; tc=1 while count=9; wrap high exactly once, in the cycle after 9->0.
REQ-036 From count=0, apply en=1, up_dn=0 -> count 9; wrap pulses; with SATURATE=1, count stays 0, wrap still pulses, and tc stays 1.
REQ-037 Apply load=1, load_val=12 -> count=9 and load_err=1; then clr -> count=0 with load_err still 1; then reset pulse -> load_err=0.
REQ-038 Apply clr=1, load=1, en=1 together at count=9 -> count=0 and no wrap pulse; load=1, en=1 with load_val=4 -> count=4.
REQ-039 Drive reset low asynchronously between CLK edges at count=7 -> count=0 immediately, before the next edge.
REQ-040 With MODULUS=16, count up through 15 -> count returns to 0 with a single wrap pulse; count down from 0 -> count 15.

Source files
------------

// File: rtl/mod_counter.sv
// mod_counter: up/down modulo counter with wrap-or-saturate terminal behaviour.
//
// Parameters
//   WIDTH    count width in bits (2..32)
//   MODULUS  count range 0..MODULUS-1 (2..2**WIDTH)
//   SATURATE 0 = wrap at the range ends, 1 = hold at the range ends
//
// Ports
//   CLK       sole clock, rising edge
//   reset     asynchronous active-low reset
//   en        count enable, one step per enabled cycle
//   up_dn     direction, 1 = increment, 0 = decrement
//   clr       synchronous clear (highest priority)
//   load      synchronous parallel load (below clr, above en)
//   load_val  value applied on load; out-of-range loads clamp to MODULUS-1
//   count     registered current count
//   tc        combinational terminal count, gated by en and up_dn
//   wrap      registered one-cycle pulse after an enabled step taken at the terminal
//   load_err  sticky flag for an out-of-range load, cleared only by reset
module mod_counter #(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  // Largest legal count. When MODULUS == 2**WIDTH this is all ones, so a
  // load can never be out of range and plain WIDTH-bit arithmetic wraps.
  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] count_d;
  logic             wrap_d;
  logic             load_err_d;
  logic             at_top;
  logic             at_bot;
  logic             load_oob;

  assign at_top   = (count == MaxVal);
  assign at_bot   = (count == '0);
  assign load_oob = (load_val > MaxVal);
  assign tc       = en & (up_dn ? at_top : at_bot);

  always_comb begin
    count_d    = count;
    wrap_d     = 1'b0;
    load_err_d = load_err;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      if (load_oob) begin
        count_d    = MaxVal;
        load_err_d = 1'b1;
      end else begin
        count_d = load_val;
      end
    end else if (en) begin
      // tc already includes en, so it marks exactly a step taken at the limit.
      wrap_d = tc;
      if (up_dn) begin
        if (at_top) count_d = SATURATE ? count : '0;
        else        count_d = count + WIDTH'(1);
      end else begin
        if (at_bot) count_d = SATURATE ? count : MaxVal;
        else        count_d = count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      count    <= count_d;
      wrap     <= wrap_d;
      load_err <= load_err_d;
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: three instances (MODULUS 10 wrapping, MODULUS 10
// saturating, MODULUS 16 wrapping) share one stimulus stream and are each
// compared against an arithmetic reference model.
module tb_mod_counter;

  logic       CLK;
  logic       reset;
  logic       en;
  logic       up_dn;
  logic       clr;
  logic       load;
  logic [3:0] load_val;

  logic [2:0][3:0] cnt_v;
  logic [2:0]      tc_v;
  logic [2:0]      wrap_v;
  logic [2:0]      err_v;

  int    checks   = 0;
  int    failures = 0;
  string phase    = "init";

  int mods[3] = '{10, 10, 16};
  bit sats[3] = '{1'b0, 1'b1, 1'b0};
  int m_cnt[3];
  bit m_wrap[3];
  bit m_err[3];

  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_wrap10 (
    .CLK(CLK), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt_v[0]), .tc(tc_v[0]), .wrap(wrap_v[0]),
    .load_err(err_v[0])
  );

  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_sat10 (
    .CLK(CLK), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt_v[1]), .tc(tc_v[1]), .wrap(wrap_v[1]),
    .load_err(err_v[1])
  );

  mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_wrap16 (
    .CLK(CLK), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt_v[2]), .tc(tc_v[2]), .wrap(wrap_v[2]),
    .load_err(err_v[2])
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s [%s]: got %0h expected %0h", tag, phase, obs, exp);
    end
  endtask

  function automatic bit model_tc(input int i);
    return en && (up_dn ? (m_cnt[i] == mods[i] - 1) : (m_cnt[i] == 0));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i]  = 0;
      m_wrap[i] = 1'b0;
      m_err[i]  = 1'b0;
    end
  endtask

  // One clock edge of the specified behaviour, using modulo arithmetic.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      bit term;
      int nxt;
      term = model_tc(i);
      nxt  = up_dn ? (m_cnt[i] + 1) % mods[i] : (m_cnt[i] + mods[i] - 1) % mods[i];
      if (clr) begin
        m_cnt[i]  = 0;
        m_wrap[i] = 1'b0;
      end else if (load) begin
        m_wrap[i] = 1'b0;
        if (int'(load_val) >= mods[i]) begin
          m_cnt[i] = mods[i] - 1;
          m_err[i] = 1'b1;
        end else begin
          m_cnt[i] = int'(load_val);
        end
      end else if (en) begin
        m_wrap[i] = term;
        if (!(term && sats[i])) m_cnt[i] = nxt;
      end else begin
        m_wrap[i] = 1'b0;
      end
    end
  endtask

  task automatic check_tc();
    for (int i = 0; i < 3; i++)
      chk($sformatf("tc[%0d]", i), 32'(tc_v[i]), 32'(model_tc(i)));
  endtask

  task automatic check_state();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("count[%0d]", i), 32'(cnt_v[i]), 32'(m_cnt[i]));
      chk($sformatf("wrap[%0d]", i), 32'(wrap_v[i]), 32'(m_wrap[i]));
      chk($sformatf("load_err[%0d]", i), 32'(err_v[i]), 32'(m_err[i]));
    end
  endtask

  // Called just after an edge: drive, check tc, take the edge, check state.
  task automatic cycle(input bit e, input bit u, input bit c, input bit l,
                       input logic [3:0] lv);
    en = e; up_dn = u; clr = c; load = l; load_val = lv;
    #1;
    check_tc();
    @(posedge CLK);
    model_edge();
    #1;
    check_state();
  endtask

  // Reset asserted between edges must clear state before the next edge.
  task automatic async_reset();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_state();
    @(posedge CLK);
    #1;
    check_state();
    #2;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; up_dn = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    phase = "reset";
    check_state();
    en = 1'b1; up_dn = 1'b0;
    #1;
    check_tc();
    #2;
    reset = 1'b1;

    phase = "count_up_12";
    repeat (12) cycle(1, 1, 0, 0, 4'd0);

    phase = "down_from_0";
    cycle(0, 0, 1, 0, 4'd0);
    cycle(1, 0, 0, 0, 4'd0);
    cycle(0, 0, 0, 0, 4'd0);

    phase = "sat_back_to_back";
    cycle(0, 0, 1, 0, 4'd0);
    repeat (3) cycle(1, 0, 0, 0, 4'd0);

    phase = "load_oob";
    cycle(0, 0, 0, 1, 4'd12);
    cycle(0, 0, 1, 0, 4'd0);
    cycle(0, 0, 0, 0, 4'd0);
    phase = "reset_clears_err";
    async_reset();

    phase = "priority";
    cycle(0, 0, 0, 1, 4'd9);
    cycle(1, 1, 1, 1, 4'd4);
    cycle(0, 0, 0, 1, 4'd9);
    cycle(1, 1, 0, 1, 4'd4);
    cycle(0, 0, 0, 0, 4'd0);

    phase = "async_reset_at_7";
    cycle(0, 0, 0, 1, 4'd7);
    async_reset();

    phase = "direction_change";
    for (int k = 0; k < 6; k++) cycle(1, k[0], 0, 0, 4'd0);

    phase = "full_range_up";
    cycle(0, 0, 1, 0, 4'd0);
    repeat (18) cycle(1, 1, 0, 0, 4'd0);
    phase = "full_range_down";
    cycle(0, 0, 1, 0, 4'd0);
    repeat (3) cycle(1, 0, 0, 0, 4'd0);

    phase = "random";
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 63) == 0) begin
        async_reset();
      end else begin
        cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0,
              4'($urandom_range(0, 15)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
